// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns a one-shot command handshake
// into one AXI4-Lite write or read and returns the response on a response
// handshake. Used to load Num1/Num2 into the adder slave and fetch the sum.
module axi_lite_cmd_master #(
  parameter int ADDR_W      = 32,
  parameter int STALL_LIMIT = 255
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESET,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  // response side
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              m_stall,
  // write address / data / response channels
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [31:0]       M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  // read address / data channels
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WADDR_DATA = 3'd1;
  localparam logic [2:0] S_WRESP      = 3'd2;
  localparam logic [2:0] S_RADDR      = 3'd3;
  localparam logic [2:0] S_RDATA      = 3'd4;
  localparam logic [2:0] S_RESP       = 3'd5;

  logic [2:0]        state_q,   state_d;
  logic              run_q;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [31:0]       wdata_q,   wdata_d;
  logic [3:0]        wstrb_q,   wstrb_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q,  wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              bready_q,  bready_d;
  logic              rready_q,  rready_d;
  logic              rspv_q,    rspv_d;
  logic [31:0]       rdata_q,   rdata_d;
  logic [1:0]        resp_q,    resp_d;
  logic [15:0]       stall_q,   stall_d;
  logic              waiting;

  // run_q holds cmd_ready low while reset is asserted and for no longer:
  // it rises on the first edge after release.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) run_q <= 1'b0;
    else              run_q <= 1'b1;
  end

  assign cmd_ready = run_q && (state_q == S_IDLE);

  // Next-state, channel handshakes and response capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    rspv_d    = rspv_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = S_WADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WADDR_DATA: begin
        // AW and W retire independently; leave once both have been taken.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end
      end
      S_WRESP: begin
        if (bready_q && M_AXI_BVALID) begin
          resp_d   = M_AXI_BRESP;
          rdata_d  = '0;
          bready_d = 1'b0;
          rspv_d   = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (rready_q && M_AXI_RVALID) begin
          resp_d   = M_AXI_RRESP;
          rdata_d  = M_AXI_RDATA;
          rready_d = 1'b0;
          rspv_d   = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rspv_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall counter restarts on every state change and saturates at all-ones.
  always_comb begin
    if (state_d != state_q)  stall_d = '0;
    else if (stall_q != '1)  stall_d = stall_q + 16'd1;
    else                     stall_d = stall_q;
  end

  // State and registered outputs.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      rspv_q    <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      rspv_q    <= rspv_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      stall_q   <= stall_d;
    end
  end

  assign waiting = (state_q == S_WADDR_DATA) || (state_q == S_WRESP) ||
                   (state_q == S_RADDR)      || (state_q == S_RDATA);
  assign m_stall = waiting && ({16'd0, stall_q} > 32'(STALL_LIMIT));

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_RREADY  = rready_q;
  assign rsp_valid     = rspv_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: an adder register slave (Num1 @0x0,
// Num2 @0x4, sum @0x8, SLVERR/DECERR elsewhere) with programmable READY
// delays, and a scoreboard of expected responses.
module tb_axi_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid, m_stall;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  axi_lite_cmd_master #(.ADDR_W(32), .STALL_LIMIT(8)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .m_stall(m_stall),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int   aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic b_block = 1'b0;
  int   aw_wait, w_wait, ar_wait;
  int   b_hs_cnt = 0;
  logic [31:0] num1 = '0, num2 = '0;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_s, w_data_s;
  logic [3:0]  w_strb_s;
  logic        aw_hs, w_hs, a_eff, w_eff;
  logic [31:0] addr_eff, data_eff;
  logic [3:0]  strb_eff;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  assign awready  = awvalid && (aw_wait >= aw_delay);
  assign wready   = wvalid && (w_wait >= w_delay);
  assign arready  = arvalid && (ar_wait >= ar_delay);
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign a_eff    = aw_got || aw_hs;
  assign w_eff    = w_got || w_hs;
  assign addr_eff = aw_hs ? awaddr : aw_addr_s;
  assign data_eff = w_hs ? wdata : w_data_s;
  assign strb_eff = w_hs ? wstrb : w_strb_s;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
      bvalid <= 1'b0; bresp <= '0;
      rvalid <= 1'b0; rresp <= '0; rdata <= '0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready)   ? w_wait + 1  : 0;
      ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
      if (bvalid && bready) begin
        bvalid   <= 1'b0;
        b_hs_cnt <= b_hs_cnt + 1;
      end
      if (a_eff && w_eff && !bvalid && !b_block) begin
        case (addr_eff)
          32'h0:   begin num1 <= merge(num1, data_eff, strb_eff); bresp <= 2'd0; end
          32'h4:   begin num2 <= merge(num2, data_eff, strb_eff); bresp <= 2'd0; end
          default: bresp <= 2'd2;
        endcase
        bvalid <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_addr_s <= awaddr; end
        if (w_hs)  begin w_got <= 1'b1; w_data_s <= wdata; w_strb_s <= wstrb; end
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        case (araddr)
          32'h0:   begin rdata <= num1;        rresp <= 2'd0; end
          32'h4:   begin rdata <= num2;        rresp <= 2'd0; end
          32'h8:   begin rdata <= num1 + num2; rresp <= 2'd0; end
          default: begin rdata <= '0;          rresp <= 2'd3; end
        endcase
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] m_n1 = '0, m_n2 = '0;
  logic [33:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    logic [33:0] e;
    if (wr) begin
      case (a)
        32'h0:   begin m_n1 = merge(m_n1, d, s); e = {2'd0, 32'd0}; end
        32'h4:   begin m_n2 = merge(m_n2, d, s); e = {2'd0, 32'd0}; end
        default: e = {2'd2, 32'd0};
      endcase
    end else begin
      case (a)
        32'h0:   e = {2'd0, m_n1};
        32'h4:   e = {2'd0, m_n2};
        32'h8:   e = {2'd0, m_n1 + m_n2};
        default: e = {2'd3, 32'd0};
      endcase
    end
    exp_q.push_back(e);
  endtask

  // Issue one command, wait for its response, compare against the scoreboard,
  // hold rsp_ready low for 'hold' cycles (optionally offering a new command).
  task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold, input logic poke,
                        output int lat);
    logic [33:0] e;
    bit ok;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    model_push(wr, a, d, s);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b, required 1 within 50 cycles", cmd_ready);
    end
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      tick();
      lat++;
    end
    e = exp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b, required 1 within 100 cycles", rsp_valid);
      return;
    end
    checks++;
    if (rsp_rdata !== e[31:0]) begin
      errors++;
      $display("FAIL rsp_rdata addr=%h: got %h, required %h", a, rsp_rdata, e[31:0]);
    end
    checks++;
    if (rsp_resp !== e[33:32]) begin
      errors++;
      $display("FAIL rsp_resp addr=%h: got %0d, required %0d", a, rsp_resp, e[33:32]);
    end
    for (int h = 0; h < hold; h++) begin
      if (poke) begin cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4; end
      tick();
      checks++;
      if ({rsp_valid, cmd_ready, rsp_rdata, rsp_resp} !== {1'b1, 1'b0, e[31:0], e[33:32]}) begin
        errors++;
        $display("FAIL rsp_hold cycle %0d: valid=%b cmd_ready=%b rdata=%h resp=%0d, required 1 0 %h %0d",
                 h, rsp_valid, cmd_ready, rsp_rdata, rsp_resp, e[31:0], e[33:32]);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_release: rsp_valid=%b cmd_ready=%b, required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, cmd_ready, rsp_valid, m_stall,
         rsp_resp, rsp_rdata, awaddr, wdata, wstrb, araddr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero (cmd_ready=%b rsp_valid=%b), required all 0",
               cmd_ready, rsp_valid);
    end
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_now: cmd_ready=%b, required 0", cmd_ready);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_next: cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_write_num1();
    int lat;
    bit seen;
    aw_delay = 0; w_delay = 0;
    seen = 1'b0;
    fork
      do_cmd(1'b1, 32'h0, 32'h12, 4'hF, 0, 1'b0, lat);
      begin
        for (int i = 0; i < 20 && !seen; i++) begin
          tick();
          if (awvalid) seen = 1'b1;
        end
        checks++;
        if ({wvalid, awready, wready, awaddr, wdata, wstrb} !== {3'b111, 32'h0, 32'h12, 4'hF}) begin
          errors++;
          $display("FAIL aw_w_same_cycle: wv=%b awr=%b wr=%b addr=%h data=%h strb=%h, required 1 1 1 0 12 f",
                   wvalid, awready, wready, awaddr, wdata, wstrb);
        end
        tick();
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
          errors++;
          $display("FAIL aw_w_drop: awvalid=%b wvalid=%b bready=%b, required 0 0 1", awvalid, wvalid, bready);
        end
      end
    join
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL write_latency: got %0d cycles, required 3", lat);
    end
  endtask

  task automatic test_read_sum();
    int lat;
    do_cmd(1'b1, 32'h4, 32'h34, 4'hF, 0, 1'b0, lat);
    do_cmd(1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL read_latency: got %0d cycles, required 3", lat);
    end
    do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, lat);
  endtask

  task automatic test_aw_before_w();
    int lat;
    int b0;
    bit seen;
    aw_delay = 0; w_delay = 4;
    b0 = b_hs_cnt;
    seen = 1'b0;
    fork
      do_cmd(1'b1, 32'h4, 32'h0000_5600, 4'h2, 0, 1'b0, lat);
      begin
        for (int i = 0; i < 20 && !seen; i++) begin
          tick();
          if (awvalid && awready) seen = 1'b1;
        end
        tick();
        checks++;
        if ({awvalid, wvalid} !== 2'b01) begin
          errors++;
          $display("FAIL aw_first: awvalid=%b wvalid=%b, required 0 1", awvalid, wvalid);
        end
      end
    join
    w_delay = 0;
    checks++;
    if (b_hs_cnt - b0 !== 1) begin
      errors++;
      $display("FAIL b_handshakes: got %0d, required 1", b_hs_cnt - b0);
    end
    do_cmd(1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b0, lat);
  endtask

  task automatic test_rsp_backpressure();
    int lat;
    do_cmd(1'b0, 32'h8, 32'h0, 4'h0, 10, 1'b1, lat);
  endtask

  task automatic test_stall();
    int lat;
    bit seen;
    ar_delay = 20;
    seen = 1'b0;
    fork
      do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, lat);
      begin
        for (int i = 0; i < 20 && !seen; i++) begin
          tick();
          if (arvalid) seen = 1'b1;
        end
        for (int c = 0; c <= 20; c++) begin
          if (c == 8 || c == 9 || c == 19) begin
            checks++;
            if ({arvalid, m_stall} !== {1'b1, (c >= 9)}) begin
              errors++;
              $display("FAIL stall_cycle%0d: arvalid=%b m_stall=%b, required 1 %b",
                       c, arvalid, m_stall, (c >= 9));
            end
          end
          if (c < 20) tick();
        end
        tick();
        checks++;
        if (m_stall !== 1'b0) begin
          errors++;
          $display("FAIL stall_clear: m_stall=%b, required 0", m_stall);
        end
      end
    join
    ar_delay = 0;
  endtask

  task automatic test_errors();
    int lat;
    do_cmd(1'b1, 32'hC, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, lat);
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, lat);
    do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic wr;
    logic [31:0] a;
    logic [3:0] s;
    for (int i = 0; i < 10; i++) begin
      aw_delay = int'($urandom_range(0, 3));
      w_delay  = int'($urandom_range(0, 3));
      ar_delay = int'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      a  = wr ? {29'd0, 1'($urandom_range(0, 1)), 2'b00} : 32'(4 * $urandom_range(0, 2));
      s  = 4'($urandom_range(1, 15));
      do_cmd(wr, a, $urandom, s, int'($urandom_range(0, 2)), 1'b0, lat);
    end
    aw_delay = 0; w_delay = 0; ar_delay = 0;
  endtask

  task automatic test_reset_in_wresp();
    int lat;
    bit ok;
    b_block = 1'b1;
    cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'hAB; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bready) ok = 1'b1;
      else tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reach_wresp: bready=%b, required 1 within 20 cycles", bready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, cmd_ready, rsp_valid, m_stall,
         rsp_resp, rsp_rdata, awaddr, wdata, wstrb, araddr} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: bready=%b awaddr=%h wdata=%h, required all 0",
               bready, awaddr, wdata);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    b_block = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release_now: cmd_ready=%b, required 0", cmd_ready);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_release_next: cmd_ready=%b, required 1", cmd_ready);
    end
    do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_num1();
    test_read_sum();
    test_aw_before_w();
    test_rsp_backpressure();
    test_stall();
    test_errors();
    test_back_to_back();
    test_reset_in_wresp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
